// File: rtl/apb_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer
// Purpose  : APB slave timer. It holds a prescaled 64-bit free-running
//            counter, a 64-bit compare with optional auto-reload, and a level
//            interrupt.
// Ports    : clk_i, rst_i (async, active-high)
//            psel_i/penable_i/pwrite_i/paddr_i/pwdata_i : APB request
//            prdata_o/pready_o/pslverr_o                : APB response
//            irq_o                                      : timer interrupt
// Registers: 0 CTRL {autoreload, irq_en, en}, 1 PRESCALE, 2 COUNT_LO,
//            3 COUNT_HI, 4 CMP_LO, 5 CMP_HI, 6 STATUS (W1C pending),
//            7 unmapped (slave error)
// Option   : APB_TIMER_SNAPSHOT_EN - a COUNT_LO read latches count[63:32]
//            into a shadow register, and COUNT_HI reads return that shadow.
// Revision : 1.0 - initial release
// ============================================================================
module apb_timer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]           pwdata_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic                  irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0]                r_idx;
    logic                      r_write;
    logic [31:0]               r_wdata;
    logic [31:0]               r_prdata;
    logic                      r_pslverr;
    logic                      r_en;
    logic                      r_irq_en;
    logic                      r_autoreload;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_psc_cnt;
    logic [63:0]               r_count;
    logic [63:0]               r_cmp;
    logic                      r_pending;
    logic                      r_irq;

    logic        w_apply;
    logic        w_wr;
    logic        w_tick;
    logic        w_match;
    logic [63:0] w_count_next;
    logic [31:0] w_rdata;
    logic [31:0] w_count_hi_rd;

    // Only the register index is decoded; the other address bits are ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{paddr_i[ADDR_WIDTH-1:5], paddr_i[1:0]};

    // ------------------------------------------------------------------------
    // APB handshake: IDLE captures the request, WAIT applies it, RESP
    // reports completion for exactly one cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (psel_i && penable_i) w_state_next = ST_WAIT;
            ST_WAIT: w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx   <= 3'd0;
            r_write <= 1'b0;
            r_wdata <= 32'd0;
        end else if (r_state == ST_IDLE && psel_i && penable_i) begin
            r_idx   <= paddr_i[4:2];
            r_write <= pwrite_i;
            r_wdata <= pwdata_i;
        end
    end

    // The transfer is applied in WAIT even if psel_i has dropped.
    assign w_apply  = (r_state == ST_WAIT);
    assign w_wr     = w_apply && r_write;
    assign pready_o = (r_state == ST_RESP);
    assign prdata_o  = r_prdata;
    assign pslverr_o = r_pslverr;
    assign irq_o     = r_irq;

`ifdef APB_TIMER_SNAPSHOT_EN
    logic [31:0] r_shadow_hi;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shadow_hi <= 32'd0;
        end else if (w_apply && !r_write && r_idx == 3'd2) begin
            r_shadow_hi <= r_count[63:32];
        end
    end

    assign w_count_hi_rd = r_shadow_hi;
`else
    assign w_count_hi_rd = r_count[63:32];
`endif

    always_comb begin
        w_rdata = 32'd0;
        case (r_idx)
            3'd0:    w_rdata = {29'd0, r_autoreload, r_irq_en, r_en};
            3'd1:    w_rdata = 32'(r_prescale);
            3'd2:    w_rdata = r_count[31:0];
            3'd3:    w_rdata = w_count_hi_rd;
            3'd4:    w_rdata = r_cmp[31:0];
            3'd5:    w_rdata = r_cmp[63:32];
            3'd6:    w_rdata = {31'd0, r_pending};
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prdata  <= 32'd0;
            r_pslverr <= 1'b0;
        end else if (w_apply) begin
            r_prdata  <= r_write ? 32'd0 : w_rdata;
            r_pslverr <= (r_idx == 3'd7);
        end else if (r_state == ST_RESP) begin
            r_pslverr <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en         <= 1'b0;
            r_irq_en     <= 1'b0;
            r_autoreload <= 1'b0;
            r_prescale   <= '0;
            r_cmp        <= 64'd0;
        end else if (w_wr) begin
            case (r_idx)
                3'd0: begin
                    r_en         <= r_wdata[0];
                    r_irq_en     <= r_wdata[1];
                    r_autoreload <= r_wdata[2];
                end
                3'd1:    r_prescale    <= r_wdata[PRESCALE_WIDTH-1:0];
                3'd4:    r_cmp[31:0]   <= r_wdata;
                3'd5:    r_cmp[63:32]  <= r_wdata;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Prescaler, counter, and match
    // ------------------------------------------------------------------------
    assign w_tick  = r_en && (r_psc_cnt == r_prescale);
    assign w_match = w_tick && (r_count == r_cmp);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_psc_cnt <= '0;
        end else if (w_wr && (r_idx == 3'd0 || r_idx == 3'd1)) begin
            r_psc_cnt <= '0;
        end else if (r_en) begin
            r_psc_cnt <= w_tick ? '0 : r_psc_cnt + 1'b1;
        end
    end

    // A software write to either half wins over a same-cycle tick. The
    // other half keeps its pre-tick value, and the increment is lost.
    always_comb begin
        w_count_next = r_count;
        if (w_tick) begin
            w_count_next = (w_match && r_autoreload) ? 64'd0 : r_count + 64'd1;
        end
        if (w_wr && r_idx == 3'd2) begin
            w_count_next = {r_count[63:32], r_wdata};
        end else if (w_wr && r_idx == 3'd3) begin
            w_count_next = {r_wdata, r_count[31:0]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= 64'd0;
        end else begin
            r_count <= w_count_next;
        end
    end

    // If a new match and a W1C arrive in the same cycle, the set wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_match) begin
                r_pending <= 1'b1;
            end else if (w_wr && r_idx == 3'd6 && r_wdata[0]) begin
                r_pending <= 1'b0;
            end
            r_irq <= r_pending && r_irq_en;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_timer
// Purpose  : Self-checking bench for apb_timer. It applies a vector table of
//            register accesses and then hand-timed sequences for the
//            counter, match, and interrupt corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    apb_timer dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        logic        chk_data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Starts at a negedge and returns at the negedge where pready is seen.
    // The expectation is queued when the request is driven, then popped
    // when the response appears.
    task automatic xfer(input string name, input logic wr, input logic [2:0] idx,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        exp_t e;
        int   lat;
        logic got;
        e.name = name; e.data = ed; e.err = ee; e.chk_data = !wr;
        sb.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {27'd0, idx, 2'b00}; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        lat = 0; got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (pready) got = 1'b1;
        end
        check({name, "_latency"}, 64'(lat), 64'd2);
        e = sb.pop_front();
        if (got) begin
            check({e.name, "_pslverr"}, 64'(pslverr), 64'(e.err));
            if (e.chk_data) check({e.name, "_prdata"}, 64'(prdata), 64'(e.data));
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] wd);
        xfer("wr", 1'b1, idx, wd, 32'd0, 1'b0);
    endtask

    task automatic add_vec(input logic w, input logic [2:0] idx, input logic [31:0] wd,
                           input logic [31:0] ed, input logic ee);
        vec_t v;
        v.wr = w; v.idx = idx; v.wdata = wd; v.exp_data = ed; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    initial begin
        // Vector table: reset readback, register readback, and the unmapped index.
        for (int i = 0; i < 7; i++) add_vec(1'b0, 3'(i), 32'd0, 32'd0, 1'b0);
        add_vec(1'b1, 3'd0, 32'hFFFF_FFFA, 32'd0, 1'b0);
        add_vec(1'b0, 3'd0, 32'd0, 32'h2, 1'b0);
        add_vec(1'b1, 3'd1, 32'hABCD_1234, 32'd0, 1'b0);
        add_vec(1'b0, 3'd1, 32'd0, 32'h1234, 1'b0);
        add_vec(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        add_vec(1'b0, 3'd4, 32'd0, 32'hDEAD_BEEF, 1'b0);
        add_vec(1'b1, 3'd5, 32'h0123_4567, 32'd0, 1'b0);
        add_vec(1'b0, 3'd5, 32'd0, 32'h0123_4567, 1'b0);
        add_vec(1'b1, 3'd2, 32'h89AB_CDEF, 32'd0, 1'b0);
        add_vec(1'b0, 3'd2, 32'd0, 32'h89AB_CDEF, 1'b0);
        add_vec(1'b1, 3'd3, 32'h7654_3210, 32'd0, 1'b0);
        add_vec(1'b0, 3'd3, 32'd0, 32'h7654_3210, 1'b0);
        add_vec(1'b1, 3'd7, 32'hFFFF_FFFF, 32'd0, 1'b1);
        add_vec(1'b0, 3'd7, 32'd0, 32'd0, 1'b1);
        add_vec(1'b0, 3'd0, 32'd0, 32'h2, 1'b0);
        add_vec(1'b0, 3'd1, 32'd0, 32'h1234, 1'b0);
        add_vec(1'b0, 3'd4, 32'd0, 32'hDEAD_BEEF, 1'b0);
        add_vec(1'b0, 3'd3, 32'd0, 32'h7654_3210, 1'b0);
        add_vec(1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
        add_vec(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_pready", 64'(pready), 64'd0);
        check("reset_pslverr", 64'(pslverr), 64'd0);
        check("reset_prdata", 64'(prdata), 64'd0);
        check("reset_irq", 64'(irq), 64'd0);

        foreach (vecs[i]) begin
            xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].idx, vecs[i].wdata,
                 vecs[i].exp_data, vecs[i].exp_err);
        end

        // psel drops in the wait state, and the write must still land.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h77;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (3) @(negedge clk);
        xfer("psel_drop_write", 1'b0, 3'd1, 32'd0, 32'h77, 1'b0);

        // Match interrupt. CTRL's write returns in cycle C0 with count=0 and a
        // tick every cycle. The match is in C5, pending in C6, irq in C7.
        wr(3'd2, 32'd0); wr(3'd3, 32'd0);
        wr(3'd4, 32'd5); wr(3'd5, 32'd0);
        wr(3'd1, 32'd0); wr(3'd0, 32'h3);
        repeat (6) @(negedge clk);
        check("irq_before_match", 64'(irq), 64'd0);
        @(negedge clk);
        check("irq_after_match", 64'(irq), 64'd1);
        xfer("status_pending", 1'b0, 3'd6, 32'd0, 32'd1, 1'b0);
        wr(3'd6, 32'd1);
        @(negedge clk);
        check("irq_after_w1c", 64'(irq), 64'd0);

        // Prescale 3. Ticks land in C3, C7, ... and the disabling write issued
        // in C40 leaves en high through C42, so count is 10.
        wr(3'd0, 32'd0); wr(3'd2, 32'd0); wr(3'd3, 32'd0);
        wr(3'd1, 32'd3); wr(3'd0, 32'h1);
        repeat (40) @(negedge clk);
        wr(3'd0, 32'd0);
        xfer("prescale_count", 1'b0, 3'd2, 32'd0, 32'd10, 1'b0);
        repeat (5) @(negedge clk);
        xfer("frozen_count", 1'b0, 3'd2, 32'd0, 32'd10, 1'b0);

        // Auto-reload with CMP=2 gives count(Ck) = k % 3. A read issued in Cs
        // samples count in C(s+2).
        wr(3'd2, 32'd0); wr(3'd3, 32'd0); wr(3'd4, 32'd2); wr(3'd5, 32'd0);
        wr(3'd1, 32'd0); wr(3'd6, 32'd1); wr(3'd0, 32'h7);
        for (int i = 0; i < 6; i++) begin
            xfer($sformatf("reload_seq%0d", i), 1'b0, 3'd2, 32'd0, 32'((4 * i + 2) % 3), 1'b0);
            @(negedge clk);
        end
        // A W1C issued in C24 applies in C26, where count is 2, so the set wins.
        wr(3'd6, 32'd1);
        @(negedge clk);
        check("w1c_vs_match_irq", 64'(irq), 64'd1);
        // A W1C issued in C28 applies in C30 (count 0), so irq is low in C32.
        wr(3'd6, 32'd1);
        @(negedge clk);
        check("w1c_no_match_irq", 64'(irq), 64'd0);

        // Carry across the 32-bit boundary: three ticks from 0x0_FFFFFFFF.
        wr(3'd0, 32'd0); wr(3'd2, 32'hFFFF_FFFF); wr(3'd3, 32'd0);
        wr(3'd0, 32'h1); wr(3'd0, 32'd0);
        xfer("carry_hi", 1'b0, 3'd3, 32'd0, 32'd1, 1'b0);
        xfer("carry_lo", 1'b0, 3'd2, 32'd0, 32'd2, 1'b0);
        // COUNT_LO=7 lands on the tick where count is 1_FFFFFFFF. HI stays 1,
        // and three more ticks follow.
        wr(3'd2, 32'hFFFF_FFFD);
        wr(3'd0, 32'h1); wr(3'd2, 32'd7); wr(3'd0, 32'd0);
        xfer("tick_write_lo", 1'b0, 3'd2, 32'd0, 32'hA, 1'b0);
        xfer("tick_write_hi", 1'b0, 3'd3, 32'd0, 32'd1, 1'b0);

        // Coherent read: LO samples 0_FFFFFFFF, and HI is read after the carry.
        wr(3'd2, 32'hFFFF_FFFD); wr(3'd3, 32'd0);
        wr(3'd0, 32'h1);
        xfer("snap_lo", 1'b0, 3'd2, 32'd0, 32'hFFFF_FFFF, 1'b0);
`ifdef APB_TIMER_SNAPSHOT_EN
        xfer("snap_hi", 1'b0, 3'd3, 32'd0, 32'd0, 1'b0);
`else
        xfer("snap_hi", 1'b0, 3'd3, 32'd0, 32'd1, 1'b0);
`endif
        wr(3'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
